// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//
// Round-robin arbiter sharing one downstream resource among NUM_REQ requesters.
// A winner receives a registered one-hot grant and keeps it until it signals
// done, drops its request, or has held it for MAX_HOLD cycles (0 = no limit).
// Priority then rotates so the requester just above the last winner goes first.
// Every ownership is followed by at least one idle cycle.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_req          per-requester level request
//   i_done         owner finished; ignored while no grant is active
//   o_grant        registered one-hot grant, zero when idle
//   o_grant_idx    binary index of the owner, zero when idle
//   o_grant_valid  registered, equals |o_grant
//   o_timeout      one-cycle pulse after a grant is revoked by the hold limit

module rr_grant_arbiter #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_done,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid,
    output logic               o_timeout
);

    localparam int unsigned    CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {StIdle, StGranted} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_valid;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic [NUM_REQ-1:0] w_upper_mask;
    logic [NUM_REQ-1:0] w_req_upper;
    logic [IDX_W-1:0]   w_upper_idx;
    logic [IDX_W-1:0]   w_any_idx;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_any_req;
    logic               w_upper_hit;
    logic               w_normal_rel;
    logic               w_hold_hit;

    // Requesters strictly above the last winner get first pick.
    always_comb begin
        w_upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper_mask[i] = (IDX_W'(i) > r_last);
        end
    end

    assign w_req_upper = i_req & w_upper_mask;
    assign w_any_req   = |i_req;
    assign w_upper_hit = |w_req_upper;

    // Two lowest-set-bit encodes (masked and unmasked) are equivalent to one
    // search over the doubled vector {req, req & mask}, kept a single level deep.
    always_comb begin
        w_upper_idx = '0;
        w_any_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_upper[i]) begin
                w_upper_idx = IDX_W'(i);
            end
            if (i_req[i]) begin
                w_any_idx = IDX_W'(i);
            end
        end
    end

    assign w_win_idx    = w_upper_hit ? w_upper_idx : w_any_idx;
    assign w_win_onehot = NUM_REQ'(1) << w_win_idx;

    // Normal release wins over the hold limit when both apply.
    assign w_normal_rel = i_done || !i_req[r_grant_idx];
    assign w_hold_hit   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_last        <= LAST_RST;
            r_hold_cnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_state       <= StGranted;
                        r_grant       <= w_win_onehot;
                        r_grant_idx   <= w_win_idx;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= CNT_W'(1);
                        r_last        <= w_win_idx;
                    end
                end
                StGranted: begin
                    if (w_normal_rel || w_hold_hit) begin
                        r_state       <= StIdle;
                        r_grant       <= '0;
                        r_grant_idx   <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_timeout     <= !w_normal_rel;
                    end else if ((MAX_HOLD != 0) && (r_hold_cnt != HOLD_MAX)) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_idx   = r_grant_idx;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (NUM_REQ=8, MAX_HOLD=4): directed scenarios with
// fixed expectations, then randomized traffic against a behavioural model.

module tb_rr_grant_arbiter;

    localparam int N  = 8;
    localparam int MH = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         grant_valid;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    rr_grant_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural model: owner is -1 when idle.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= N - 1;
            m_held  <= 0;
            m_tmo   <= 1'b0;
        end else if (m_owner < 0) begin
            m_tmo <= 1'b0;
            if (req != '0) begin
                m_owner <= pick(req, m_last);
                m_last  <= pick(req, m_last);
                m_held  <= 1;
            end
        end else if (done || !req[m_owner]) begin
            m_owner <= -1;
            m_tmo   <= 1'b0;
        end else if (m_held >= MH) begin
            m_owner <= -1;
            m_tmo   <= 1'b1;
        end else begin
            m_held <= m_held + 1;
            m_tmo  <= 1'b0;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            cyc();
            checks++;
            if ({grant_valid, grant_idx, grant, timeout} !== 13'd0) begin
                $display("FAIL reset_hold: got %b expected all zero",
                         {grant_valid, grant_idx, grant, timeout});
                errors++;
            end
        end
        rst = 1'b0;
        cyc();
        checks++;
        if ({grant_valid, grant_idx, grant, timeout} !== {1'b1, 3'd0, 8'h01, 1'b0}) begin
            $display("FAIL reset_first_grant: got v=%b idx=%0d g=%h t=%b expected v=1 idx=0 g=01 t=0",
                     grant_valid, grant_idx, grant, timeout);
            errors++;
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 2, 5, 7, 0};
        rst = 1'b1; req = '0; done = 1'b0;
        cyc();
        rst = 1'b0;
        req = 8'b1010_0101;
        for (int g = 0; g < 5; g++) begin
            cyc();
            checks++;
            if (grant !== (8'd1 << order[g]) || grant_idx !== 3'(order[g])) begin
                $display("FAIL rotation_grant%0d: got g=%h idx=%0d expected idx=%0d",
                         g, grant, grant_idx, order[g]);
                errors++;
            end
            done = 1'b1;
            cyc();
            done = 1'b0;
            checks++;
            if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
                $display("FAIL rotation_idle%0d: got v=%b t=%b expected v=0 t=0",
                         g, grant_valid, timeout);
                errors++;
            end
        end
    endtask

    task automatic test_hold_limit();
        rst = 1'b1; req = '0; done = 1'b0;
        cyc();
        rst = 1'b0;
        req = 8'h08;
        for (int c = 0; c < MH; c++) begin
            cyc();
            checks++;
            if (grant !== 8'h08 || timeout !== 1'b0) begin
                $display("FAIL hold_cycle%0d: got g=%h t=%b expected g=08 t=0", c, grant, timeout);
                errors++;
            end
        end
        cyc();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || timeout !== 1'b1) begin
            $display("FAIL hold_revoke: got g=%h v=%b t=%b expected g=00 v=0 t=1",
                     grant, grant_valid, timeout);
            errors++;
        end
        cyc();
        checks++;
        if (grant !== 8'h08 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
            $display("FAIL hold_regrant: got g=%h idx=%0d t=%b expected g=08 idx=3 t=0",
                     grant, grant_idx, timeout);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; req = '0; done = 1'b0;
        cyc();
        rst = 1'b0;
        req = 8'h08;
        for (int c = 0; c < MH; c++) cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            $display("FAIL done_at_limit: got g=%h t=%b expected g=00 t=0", grant, timeout);
            errors++;
        end
        cyc();
        cyc();
        checks++;
        if (grant !== 8'h08) begin
            $display("FAIL drop_pre: got g=%h expected g=08", grant);
            errors++;
        end
        req = 8'h00;
        cyc();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            $display("FAIL req_drop_release: got g=%h t=%b expected g=00 t=0", grant, timeout);
            errors++;
        end
    endtask

    task automatic test_no_preempt();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1; req = '0; done = 1'b0;
            cyc();
            rst = 1'b0;
            req = 8'h40;
            cyc();
            req = 8'h42;
            for (int c = 0; c < 2; c++) begin
                cyc();
                checks++;
                if (grant !== 8'h40) begin
                    $display("FAIL no_preempt%0d: got g=%h expected g=40", pass, grant);
                    errors++;
                end
            end
            if (pass == 0) req = 8'hC2;
            done = 1'b1;
            cyc();
            done = 1'b0;
            cyc();
            checks++;
            if (pass == 0 && (grant !== 8'h80 || grant_idx !== 3'd7)) begin
                $display("FAIL wrap_to7: got g=%h idx=%0d expected g=80 idx=7", grant, grant_idx);
                errors++;
            end else if (pass == 1 && (grant !== 8'h02 || grant_idx !== 3'd1)) begin
                $display("FAIL wrap_to1: got g=%h idx=%0d expected g=02 idx=1", grant, grant_idx);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        rst = 1'b1; req = '0; done = 1'b0;
        cyc();
        rst = 1'b0;
        req = 8'h20;
        cyc();
        cyc();
        checks++;
        if (grant !== 8'h20) begin
            $display("FAIL midrst_pre: got g=%h expected g=20", grant);
            errors++;
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({grant_valid, grant_idx, grant, timeout} !== 13'd0) begin
            $display("FAIL midrst_clear: got %b expected all zero",
                     {grant_valid, grant_idx, grant, timeout});
            errors++;
        end
        rst = 1'b0;
        req = 8'h21;
        cyc();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            $display("FAIL midrst_first: got g=%h idx=%0d expected g=01 idx=0", grant, grant_idx);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_grant;
        rst = 1'b1; req = '0; done = 1'b0;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom) & N'($urandom);
            done = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            cyc();
            exp_grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
            checks++;
            if (grant !== exp_grant) begin
                $display("FAIL rand_grant@%0d: got %h expected %h", n, grant, exp_grant);
                errors++;
            end
            checks++;
            if (grant_idx !== ((m_owner >= 0) ? 3'(m_owner) : 3'd0)) begin
                $display("FAIL rand_idx@%0d: got %0d expected owner %0d", n, grant_idx, m_owner);
                errors++;
            end
            checks++;
            if (grant_valid !== (m_owner >= 0)) begin
                $display("FAIL rand_valid@%0d: got %b expected %b", n, grant_valid, m_owner >= 0);
                errors++;
            end
            checks++;
            if (timeout !== m_tmo) begin
                $display("FAIL rand_timeout@%0d: got %b expected %b", n, timeout, m_tmo);
                errors++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        test_reset();
        test_rotation();
        test_hold_limit();
        test_simultaneous();
        test_no_preempt();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
